// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the dmem load/store unit.
package dmem_lsu_pkg;

   localparam int          LSU_TOTAL_DATA = 4096;
   localparam logic [31:0] LSU_MAX_ADDR   = 32'(LSU_TOTAL_DATA - 4);

   typedef enum logic [1:0] {
      BYTE    = 2'b00,
      HALF    = 2'b01,
      WORD    = 2'b10,
      ILLEGAL = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } state_t;

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational load extraction/extension and sub-word store merge.
module dmem_lsu_align
   import dmem_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] rd_word,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  size_t                 size,
   input  logic                  is_unsigned,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] store_data
);

   localparam int HALF_WIDTH = 2 * BYTE_WIDTH;

   // Low bytes of the word are the addressed bytes, since dmem reads start at the request address.
   function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] w,
                                                          input size_t sz, input logic uns);
      logic [DATA_WIDTH-1:0] res;
      case (sz)
         BYTE:    res = {{(DATA_WIDTH-BYTE_WIDTH){~uns & w[BYTE_WIDTH-1]}}, w[BYTE_WIDTH-1:0]};
         HALF:    res = {{(DATA_WIDTH-HALF_WIDTH){~uns & w[HALF_WIDTH-1]}}, w[HALF_WIDTH-1:0]};
         default: res = w;
      endcase
      return res;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_store(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [DATA_WIDTH-1:0] wd,
                                                         input size_t sz);
      logic [DATA_WIDTH-1:0] res;
      case (sz)
         BYTE:    res = {w[DATA_WIDTH-1:BYTE_WIDTH], wd[BYTE_WIDTH-1:0]};
         HALF:    res = {w[DATA_WIDTH-1:HALF_WIDTH], wd[HALF_WIDTH-1:0]};
         default: res = wd;
      endcase
      return res;
   endfunction

   assign load_data  = extract_load(rd_word, size, is_unsigned);
   assign store_data = merge_store(rd_word, wdata, size);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator: checks requests, sequences dmem reads/writes, returns responses.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int TOTAL_DATA = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_data_in,
   output logic                  dmem_wr_en,
   input  logic [DATA_WIDTH-1:0] dmem_data_out
);

   localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(TOTAL_DATA - 4);

   state_t                state_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   size_t                 size_r;
   logic                  we_r;
   logic                  unsigned_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic                  wr_en_r;
   logic [DATA_WIDTH-1:0] data_in_r;
   logic                  rsp_valid_r;
   logic                  rsp_err_r;
   logic [DATA_WIDTH-1:0] rsp_rdata_r;

   size_t                 req_size_s;
   logic                  accept_s;
   logic                  align_err_s;
   logic                  req_err_s;
   logic [DATA_WIDTH-1:0] load_data_s;
   logic [DATA_WIDTH-1:0] store_data_s;

   assign req_size_s = size_t'(req_size);
   assign req_ready  = (state_r == IDLE) && !rst;
   assign accept_s   = req_valid && req_ready;
   assign req_err_s  = align_err_s || (req_addr > MAX_ADDR);

   // Size legality and natural-alignment check on the incoming request.
   always_comb begin
      align_err_s = 1'b0;
      case (req_size_s)
         HALF:    align_err_s = req_addr[0];
         WORD:    align_err_s = |req_addr[1:0];
         ILLEGAL: align_err_s = 1'b1;
         default: align_err_s = 1'b0;
      endcase
   end

   dmem_lsu_align #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
   ) u_align (
      .rd_word     (dmem_data_out),
      .wdata       (wdata_r),
      .size        (size_r),
      .is_unsigned (unsigned_r),
      .load_data   (load_data_s),
      .store_data  (store_data_s)
   );

   // Request sequencing FSM with its request, write and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         addr_r      <= '0;
         size_r      <= BYTE;
         we_r        <= 1'b0;
         unsigned_r  <= 1'b0;
         wdata_r     <= '0;
         wr_en_r     <= 1'b0;
         data_in_r   <= '0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= '0;
      end else begin
         rsp_valid_r <= 1'b0;
         wr_en_r     <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  addr_r     <= req_addr;
                  size_r     <= req_size_s;
                  we_r       <= req_we;
                  unsigned_r <= req_unsigned;
                  wdata_r    <= req_wdata;
                  if (req_err_s) begin
                     state_r     <= RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b1;
                     rsp_rdata_r <= '0;
                  end else if (req_we && (req_size_s == WORD)) begin
                     state_r   <= WRITE;
                     wr_en_r   <= 1'b1;
                     data_in_r <= req_wdata;
                  end else begin
                     state_r <= READ;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            READ: begin
               if (we_r) begin
                  state_r   <= WRITE;
                  wr_en_r   <= 1'b1;
                  data_in_r <= store_data_s;
               end else begin
                  state_r     <= RESP;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= 1'b0;
                  rsp_rdata_r <= load_data_s;
               end
            end
            WRITE: begin
               state_r     <= RESP;
               rsp_valid_r <= 1'b1;
               rsp_err_r   <= 1'b0;
               rsp_rdata_r <= '0;
            end
            RESP:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   // Reset gates the strobe combinationally so a reset in WRITE never commits.
   assign dmem_wr_en   = wr_en_r && !rst;
   assign dmem_addr    = addr_r;
   assign dmem_data_in = data_in_r;
   assign rsp_valid    = rsp_valid_r;
   assign rsp_err      = rsp_err_r;
   assign rsp_rdata    = rsp_rdata_r;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator that sits between the core's memory stage and `dmem`. Accepts byte/halfword/word load and store requests over a valid/ready handshake, drives the word-wide, byte-addressed `dmem` port, and returns sign- or zero-extended load data. `dmem` always writes four bytes, so sub-word stores are done as read-modify-write sequences. Alignment and range checks are enforced before any memory access.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width
- `BYTE_WIDTH`, 8, byte width
- `TOTAL_DATA`, 4096, `dmem` size in bytes; used for the range check
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  zero-extend loads (ignored for word and for stores)
- `req_addr`  in  ADDR_WIDTH  byte address
- `req_wdata`  in  DATA_WIDTH  store data, right-justified
- `rsp_valid`  out  1  one-cycle response strobe
- `rsp_err`  out  1  request rejected (qualified by `rsp_valid`)
- `rsp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors
- `dmem_addr`  out  ADDR_WIDTH  to `dmem`
- `dmem_data_in`  out  DATA_WIDTH  to `dmem`
- `dmem_wr_en`  out  1  to `dmem`
- `dmem_data_out`  in  DATA_WIDTH  from `dmem`; combinational, little-endian (bits 7:0 = byte at `dmem_addr`)

## Operation
- States: IDLE, READ, WRITE, RESP. `req_ready` = (state==IDLE) && !rst.
- On accept (`req_valid && req_ready`), register addr, size, we, unsigned, and wdata. Then check:
  - error if size==11;
  - error if half with addr[0]!=0;
  - error if word with addr[1:0]!=0;
  - error if addr > TOTAL_DATA-4.
- Transitions from IDLE on accept:
  - error → RESP
  - load → READ
  - word store → WRITE
  - byte/half store → READ
- READ: capture `dmem_data_out` into the word register. A load goes to RESP. A sub-word store goes to WRITE.
- Load data extraction from the captured word:
  - byte → bits 7:0, half → bits 15:0, word → all 32 bits.
  - Sign-extend unless `req_unsigned`.
- Sub-word store merge:
  - byte → {word[31:8], wdata[7:0]}
  - half → {word[31:16], wdata[15:0]}
- Word store data = wdata.
- WRITE: `dmem_wr_en`=1 for exactly one cycle with `dmem_data_in` = merged/word data. Next state is RESP.
- RESP: `rsp_valid`=1 for one cycle with `rsp_err` and `rsp_rdata`. Next state is IDLE. There is no response backpressure.
- `dmem_addr` = registered request address at all times.
- `dmem_wr_en` is 0 outside WRITE and is forced to 0 while `rst` is high.
- An errored request never asserts `dmem_wr_en`.

## Timing
- Latency is counted from the accept cycle (cycle 0) to the `rsp_valid` cycle:
  - error: 1
  - load: 2
  - word store: 2 (write commits at end of cycle 1)
  - byte/half store: 3 (read in cycle 1, write in cycle 2)
- Throughput is one request in flight. `req_ready` deasserts from cycle 1 until the cycle after RESP. A new request can be accepted in the cycle following `rsp_valid`.
- Reset values: state IDLE; all registers 0; `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `dmem_wr_en`=0, `dmem_addr`=0, `dmem_data_in`=0.
- Reset mid-operation aborts the request. If `rst` is high during the WRITE cycle, no write occurs and no response is issued.
- `rsp_rdata` and `rsp_err` hold their last values between responses. They are meaningful only with `rsp_valid`.

## Structure
- Package `dmem_lsu_pkg` holds:
  - the `size_t` enum (BYTE/HALF/WORD/ILLEGAL);
  - the `state_t` enum (IDLE/READ/WRITE/RESP);
  - constant `LSU_MAX_ADDR = TOTAL_DATA-4` computed from the default.
- Sub-module `dmem_lsu_align` (combinational) contains the load extraction/extension and store merge functions. The top level contains the FSM and registers.
- Bench instantiates the real `dmem` with a known `data_memory.mem` preload.

## Test plan
- Preload bytes 0x10..0x13 = 80 7F 34 12, then issue loads:
  - `lb` @0x10 → FFFFFF80
  - `lbu` @0x10 → 00000080
  - `lh` @0x10 → 00007F80
  - `lw` @0x10 → 12347F80, `rsp_valid` in cycle 2, `rsp_err`=0
- `sb` 0xAB @0x11 → READ then a single WRITE cycle; following `lw` @0x10 → 1234AB80; store response arrives in cycle 3.
- `sw` 0xDEADBEEF @0x20 → `dmem_wr_en` high exactly in cycle 1; `lw` @0x20 → DEADBEEF; bytes 0x1C and 0x24 unchanged.
- Errors each yield `rsp_err`=1 in cycle 1 with `dmem_wr_en` never high:
  - `lh` @0x11
  - `sw` @0x22
  - `sw` @0xFFD (TOTAL_DATA 4096)
  - size=11
- Back-to-back: hold `req_valid` high for 3 requests → `req_ready` low while busy; each accepted the cycle after the previous `rsp_valid`; no request lost or duplicated.
- Assert `rst` during the WRITE cycle of `sh` 0x5555 @0x30 → memory @0x30 unchanged, no `rsp_valid`; after reset `req_ready`=1 and `lw` @0x30 returns the preload value.
